// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Imported by the fetch interface, skid buffer and stage top.
package fetch_pkg;

  localparam int WIDTH    = 32;
  localparam int PC_STEP  = 4;
  localparam int PC_INDEX = 32;

  typedef logic [WIDTH-1:0] regval_t;

  typedef enum logic [1:0] {
    IDLE,
    REQUEST,
    HOLDING,
    DISCARD
  } fetch_state_t;

  typedef struct packed {
    regval_t instruction;
    regval_t pc;
  } fetch_word_t;

  function automatic regval_t step_pc(input regval_t p);
    return p + regval_t'(PC_STEP);
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory read bus between fetch (master) and memory (slave).
// Address side is registered in fetch; data side completes a request.
interface fetch_if;
  import fetch_pkg::*;

  logic    address_enable;
  regval_t address;
  regval_t data;
  logic    data_valid;

  modport master (
    output address_enable,
    output address,
    input  data,
    input  data_valid
  );

  modport slave (
    input  address_enable,
    input  address,
    output data,
    output data_valid
  );

endinterface

// File: rtl/fetch_skid.sv
// One-entry {instruction, pc} buffer catching a word decode cannot take.
// Clear and unload both empty the entry; clear wins over load.
module fetch_skid
  import fetch_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic        unload,
  input  logic        clear,
  input  fetch_word_t din,
  output fetch_word_t dout,
  output logic        full
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      full <= 1'b0;
      dout <= '0;
    end else if (clear || unload) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
      dout <= din;
    end
  end

endmodule

// File: rtl/fetch.sv
// Instruction fetch stage: issues memory reads from fetch_pc, presents
// words to decode, absorbs one stalled word and discards flushed fetches.
module fetch
  import fetch_pkg::*;
(
  input  logic    clock,
  input  logic    reset,
  input  regval_t pc_in,
  input  logic    has_flushed,
  fetch_if.master mem,
  input  logic    hold,
  output logic    is_valid,
  output regval_t instruction,
  output regval_t pc,
  output regval_t next_pc
);

  fetch_state_t state, state_n;
  regval_t      fetch_pc, fpc_n;
  logic         accept;
  logic         out_load, out_clear;
  logic         skid_load, skid_unload, skid_clear, skid_full;
  fetch_word_t  out_word, skid_word, mem_word;

  assign accept   = !is_valid || !hold;
  assign next_pc  = step_pc(fetch_pc);
  assign mem_word = '{instruction: mem.data, pc: fetch_pc};

  fetch_skid u_skid (
    .clock  (clock),
    .reset  (reset),
    .load   (skid_load),
    .unload (skid_unload),
    .clear  (skid_clear),
    .din    (mem_word),
    .dout   (skid_word),
    .full   (skid_full)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      fetch_pc <= '0;
    end else begin
      state    <= state_n;
      fetch_pc <= fpc_n;
    end
  end

  always_comb begin
    state_n     = state;
    fpc_n       = fetch_pc;
    out_load    = 1'b0;
    out_clear   = 1'b0;
    out_word    = mem_word;
    skid_load   = 1'b0;
    skid_unload = 1'b0;
    skid_clear  = 1'b0;
    unique case (state)
      IDLE: begin
        state_n = REQUEST;
        fpc_n   = pc_in;
      end
      REQUEST: begin
        if (has_flushed) begin
          fpc_n      = pc_in;
          out_clear  = 1'b1;
          skid_clear = 1'b1;
          state_n    = mem.data_valid ? REQUEST : DISCARD;
        end else if (mem.data_valid) begin
          fpc_n = step_pc(fetch_pc);
          if (accept) begin
            out_load = 1'b1;
          end else begin
            skid_load = 1'b1;
            state_n   = HOLDING;
          end
        end
      end
      HOLDING: begin
        if (has_flushed) begin
          fpc_n      = pc_in;
          out_clear  = 1'b1;
          skid_clear = 1'b1;
          state_n    = REQUEST;
        end else if (!hold && skid_full) begin
          out_load    = 1'b1;
          out_word    = skid_word;
          skid_unload = 1'b1;
          state_n     = REQUEST;
        end
      end
      DISCARD: begin
        // a flush landing with the late data retires that request too
        if (has_flushed) begin
          fpc_n      = pc_in;
          out_clear  = 1'b1;
          skid_clear = 1'b1;
        end
        if (mem.data_valid) begin
          state_n = REQUEST;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      is_valid    <= 1'b0;
      instruction <= '0;
      pc          <= '0;
    end else if (out_clear) begin
      is_valid <= 1'b0;
    end else if (out_load) begin
      is_valid    <= 1'b1;
      instruction <= out_word.instruction;
      pc          <= out_word.pc;
    end else if (!hold) begin
      is_valid <= 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem.address_enable <= 1'b0;
      mem.address        <= '0;
    end else begin
      mem.address_enable <= (state_n == REQUEST);
      if (state_n == REQUEST) begin
        mem.address <= fpc_n;
      end
    end
  end

endmodule

// File: tb/tb_fetch.sv
// Directed and random bench for fetch against a queue-based fetch model.
// A latency-programmable memory answers requests from the bus.
module tb_fetch;
  import fetch_pkg::*;

  logic    clock;
  logic    reset;
  regval_t pc_in;
  logic    has_flushed;
  logic    hold;
  logic    is_valid;
  regval_t instruction;
  regval_t pc;
  regval_t next_pc;

  fetch_if mif();

  fetch dut (
    .clock       (clock),
    .reset       (reset),
    .pc_in       (pc_in),
    .has_flushed (has_flushed),
    .mem         (mif),
    .hold        (hold),
    .is_valid    (is_valid),
    .instruction (instruction),
    .pc          (pc),
    .next_pc     (next_pc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // memory model
  int      lat = 1;
  logic    mp = 1'b0;
  regval_t maddr = '0;
  int      mcnt = 0;
  logic    late_dv = 1'b0;
  logic    fired = 1'b0;

  // fetch model
  logic        m_started;
  logic        m_drop;
  logic        m_v;
  regval_t     m_ins, m_pc, m_fpc;
  logic [63:0] m_skid[$];

  function automatic regval_t mem_word(input regval_t a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_started = 1'b0;
    m_drop    = 1'b0;
    m_v       = 1'b0;
    m_ins     = '0;
    m_pc      = '0;
    m_fpc     = '0;
    m_skid.delete();
    mp        = 1'b0;
  endtask

  task automatic check_reset();
    chk("rst_valid", {31'd0, is_valid}, 32'd0);
    chk("rst_instr", instruction, 32'd0);
    chk("rst_pc", pc, 32'd0);
    chk("rst_aen", {31'd0, mif.address_enable}, 32'd0);
    chk("rst_addr", mif.address, 32'd0);
  endtask

  // called just after a negedge; returns just after the next negedge
  // fmode: 0 none, 1 flush, 2 flush if request pending without data,
  //        3 flush and hold together with data
  task automatic step(input logic h_in, input int fmode, input regval_t pin);
    logic    dv, fl, h, req;
    regval_t d;
    h = h_in;
    if (late_dv) begin
      dv = 1'b1;
      d  = 32'hDEAD_BEEF;
    end else begin
      if (!mp && mif.address_enable) begin
        mp = 1'b1; maddr = mif.address; mcnt = 1;
      end else if (mp) begin
        mcnt++;
      end
      dv = mp && (mcnt >= lat);
      d  = dv ? mem_word(maddr) : $urandom;
    end
    fl = (fmode == 1) ||
         (fmode == 2 && !dv && mif.address_enable) ||
         (fmode == 3 && dv && !late_dv);
    if (fmode == 3 && fl) h = 1'b1;
    if (fl) fired = 1'b1;
    mif.data_valid = dv;
    mif.data       = d;
    hold           = h;
    has_flushed    = fl;
    pc_in          = pin;
    #1;
    req = m_started && (m_skid.size() == 0) && !m_drop;
    chk("valid", {31'd0, is_valid}, {31'd0, m_v});
    if (m_v) begin
      chk("instr", instruction, m_ins);
      chk("pc", pc, m_pc);
    end
    chk("aen", {31'd0, mif.address_enable}, {31'd0, req});
    if (req) chk("addr", mif.address, m_fpc);
    chk("next_pc", next_pc, regval_t'(m_fpc + 32'd4));
    @(posedge clock);
    if (!m_started) begin
      m_started = 1'b1;
      m_fpc     = pin;
      if (!h) m_v = 1'b0;
    end else if (fl) begin
      m_v    = 1'b0;
      m_skid.delete();
      m_drop = (req || m_drop) && !dv;
      m_fpc  = pin;
    end else if (m_drop) begin
      if (dv) m_drop = 1'b0;
      if (!h) m_v = 1'b0;
    end else if (m_skid.size() != 0) begin
      if (!h) begin
        logic [63:0] w;
        w     = m_skid.pop_front();
        m_ins = w[63:32];
        m_pc  = w[31:0];
        m_v   = 1'b1;
      end
    end else if (dv) begin
      if (!m_v || !h) begin
        m_ins = mem_word(m_fpc);
        m_pc  = m_fpc;
        m_v   = 1'b1;
      end else begin
        m_skid.push_back({mem_word(m_fpc), m_fpc});
      end
      m_fpc = regval_t'(m_fpc + 32'd4);
    end else if (!h) begin
      m_v = 1'b0;
    end
    if (dv) mp = 1'b0;
    @(negedge clock);
  endtask

  task automatic step_until(input logic h, input int fmode,
                            input regval_t pin, input string tag);
    fired = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step(h, fmode, pin);
      if (fired) break;
    end
    chk(tag, {31'd0, fired}, 32'd1);
  endtask

  initial begin
    reset = 1'b1;
    pc_in = 32'h100;
    has_flushed = 1'b0;
    hold = 1'b0;
    mif.data = '0;
    mif.data_valid = 1'b0;
    model_reset();
    @(negedge clock);
    #1;
    check_reset();
    reset = 1'b0;

    // back-to-back, single-cycle memory
    lat = 1;
    step(1'b0, 0, 32'h100);
    #1;
    chk("first_addr", mif.address, 32'h100);
    chk("first_next", next_pc, 32'h104);
    repeat (4) step(1'b0, 0, 32'h100);

    // three-cycle memory
    lat = 3;
    repeat (10) step(1'b0, 0, 32'h100);

    // stall with data arriving while blocked
    lat = 1;
    repeat (3) step(1'b0, 0, 32'h100);
    repeat (4) step(1'b1, 0, 32'h100);
    #1;
    chk("hold_aen", {31'd0, mif.address_enable}, 32'd0);
    repeat (4) step(1'b0, 0, 32'h100);

    // flush with request outstanding, late data discarded
    lat = 3;
    step_until(1'b0, 2, 32'h200, "flush_pend");
    #1;
    chk("discard_aen", {31'd0, mif.address_enable}, 32'd0);
    repeat (8) step(1'b0, 0, 32'h200);

    // flush together with data and hold
    lat = 1;
    step_until(1'b0, 3, 32'h200, "flush_dv");
    #1;
    chk("fdv_valid", {31'd0, is_valid}, 32'd0);
    chk("fdv_addr", mif.address, 32'h200);
    repeat (3) step(1'b0, 0, 32'h200);

    // wrap of the sequential PC
    step(1'b0, 1, 32'hFFFF_FFFC);
    #1;
    chk("wrap_next", next_pc, 32'h0);
    repeat (4) step(1'b0, 0, 32'h0);

    // reset mid-request, stale data in the first cycle after release
    lat = 3;
    step(1'b0, 0, 32'h0);
    reset = 1'b1;
    #1;
    check_reset();
    model_reset();
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    late_dv = 1'b1;
    step(1'b0, 0, 32'h300);
    late_dv = 1'b0;
    repeat (6) step(1'b0, 0, 32'h300);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      regval_t pin;
      logic    h;
      int      fm;
      if ($urandom_range(0, 15) == 0) lat = $urandom_range(1, 3);
      h   = ($urandom_range(0, 9) < 3);
      fm  = ($urandom_range(0, 24) == 0) ? 1 : 0;
      pin = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8
                                        : ($urandom & 32'hFFFF_FFFC);
      step(h, fm, pin);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
